multi_channel_bus_timer: RTL and testbench

Parametrised successor to the single-channel millisecond timer. One shared prescaler turns the system clock into ticks. Each of CHANNELS independent channels counts those ticks down from its own divisor. Each channel raises an alarm in periodic or one-shot mode and has its own interrupt line. The block sits on the ECO32 peripheral bus as a zero-wait-state slave.

---
 rtl/multi_channel_bus_timer.sv | 183 ++++++++++++++++++
 tb/tb_multi_channel_bus_timer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_bus_timer
// Brief    : Shared prescaler feeding CHANNELS independent down-counting
//            timers, each with periodic/one-shot alarm and its own interrupt,
//            on a zero-wait-state peripheral bus.
//            Optional build macro TIMER_OVERRUN_EN adds a sticky CTRL bit4
//            overrun flag per channel.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_bus_timer #(
    parameter int PRESCALE      = 50000,
    parameter int CHANNEL_BITS  = 2,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          busEnable,
    input  logic                          busWrite,
    input  logic [CHANNEL_BITS+3:2]       busAddress,
    input  logic [31:0]                   busWriteData,
    output logic [31:0]                   busReadData,
    output logic                          busWait,
    output logic [(1<<CHANNEL_BITS)-1:0]  interrupt
);

    localparam int          CHANNELS    = 1 << CHANNEL_BITS;
    localparam logic [15:0] c_prescale  = 16'(PRESCALE);
    localparam logic [1:0]  c_reg_ctrl  = 2'd0;
    localparam logic [1:0]  c_reg_div   = 2'd1;
    localparam logic [1:0]  c_reg_count = 2'd2;

    logic [15:0]             r_prescaler;
    logic [15:0]             w_prescaler_d;
    logic                    w_tick;
    logic                    w_bus_wr;
    logic [CHANNEL_BITS-1:0] w_ch;
    logic [1:0]              w_reg;
    logic [31:0]             w_rd [CHANNELS];

    assign w_bus_wr    = busEnable & busWrite;
    assign w_ch        = busAddress[CHANNEL_BITS+3:4];
    assign w_reg       = busAddress[3:2];
    assign w_tick      = (r_prescaler == 16'd1);
    assign busWait     = 1'b0;
    assign busReadData = w_rd[w_ch];

    // Prescaler next value: count down to 1, then reload
    always_comb begin
        w_prescaler_d = r_prescaler - 16'd1;
        if (w_tick) begin
            w_prescaler_d = c_prescale;
        end
    end

    // Free-running prescaler register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_prescaler <= c_prescale;
        end else begin
            r_prescaler <= w_prescaler_d;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [COUNTER_WIDTH-1:0] r_div;
        logic [COUNTER_WIDTH-1:0] r_count;
        logic [COUNTER_WIDTH-1:0] w_div_d;
        logic [COUNTER_WIDTH-1:0] w_count_d;
        logic                     r_alarm, r_ie, r_oneshot, r_run;
        logic                     w_alarm_d, w_ie_d, w_oneshot_d, w_run_d;
        logic                     w_hit, w_wr_ctrl, w_wr_div, w_expire;
        logic                     w_ovr;
        logic [31:0]              w_div_rd, w_count_rd, w_sel_rd;

        assign w_hit     = w_bus_wr && (w_ch == CHANNEL_BITS'(gi));
        assign w_wr_ctrl = w_hit && (w_reg == c_reg_ctrl);
        assign w_wr_div  = w_hit && (w_reg == c_reg_div);
        // A divisor write swallows any tick landing in the same cycle
        assign w_expire  = w_tick && r_run && (r_count == COUNTER_WIDTH'(1)) && !w_wr_div;

        // Next-state for counter and control bits; CTRL writes beat expiry
        always_comb begin
            w_div_d     = r_div;
            w_count_d   = r_count;
            w_alarm_d   = r_alarm;
            w_ie_d      = r_ie;
            w_oneshot_d = r_oneshot;
            w_run_d     = r_run;
            if (w_wr_div) begin
                w_div_d   = busWriteData[COUNTER_WIDTH-1:0];
                w_count_d = busWriteData[COUNTER_WIDTH-1:0];
            end else if (w_tick && r_run) begin
                // Divisor 0 reaches all-ones via natural wrap on decrement
                if (w_expire) begin
                    w_count_d = r_div;
                end else begin
                    w_count_d = r_count - COUNTER_WIDTH'(1);
                end
            end
            if (w_wr_ctrl) begin
                w_alarm_d   = busWriteData[0];
                w_ie_d      = busWriteData[1];
                w_oneshot_d = busWriteData[2];
                w_run_d     = busWriteData[3];
            end else if (w_expire) begin
                w_alarm_d = 1'b1;
                if (r_oneshot) begin
                    w_run_d = 1'b0;
                end
            end
        end

        // Channel state registers
        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                r_div     <= '1;
                r_count   <= '1;
                r_alarm   <= 1'b0;
                r_ie      <= 1'b0;
                r_oneshot <= 1'b0;
                r_run     <= 1'b1;
            end else begin
                r_div     <= w_div_d;
                r_count   <= w_count_d;
                r_alarm   <= w_alarm_d;
                r_ie      <= w_ie_d;
                r_oneshot <= w_oneshot_d;
                r_run     <= w_run_d;
            end
        end

`ifdef TIMER_OVERRUN_EN
        logic r_ovr;
        logic w_ovr_d;

        // Sticky overrun: expiry while alarm still pending; only a bit4=0 write clears
        always_comb begin
            w_ovr_d = r_ovr | (w_expire & r_alarm);
            if (w_wr_ctrl && !busWriteData[4]) begin
                w_ovr_d = 1'b0;
            end
        end

        // Overrun flag register
        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                r_ovr <= 1'b0;
            end else begin
                r_ovr <= w_ovr_d;
            end
        end

        assign w_ovr = r_ovr;
`else
        assign w_ovr = 1'b0;
`endif

        // Zero-extend divisor and count onto the 32-bit bus
        always_comb begin
            w_div_rd                     = '0;
            w_count_rd                   = '0;
            w_div_rd[COUNTER_WIDTH-1:0]  = r_div;
            w_count_rd[COUNTER_WIDTH-1:0] = r_count;
        end

        // Per-channel register select for reads
        always_comb begin
            w_sel_rd = 32'd0;
            case (w_reg)
                c_reg_ctrl:  w_sel_rd = {27'd0, w_ovr, r_run, r_oneshot, r_ie, r_alarm};
                c_reg_div:   w_sel_rd = w_div_rd;
                c_reg_count: w_sel_rd = w_count_rd;
                default:     w_sel_rd = 32'd0;
            endcase
        end

        assign w_rd[gi]      = w_sel_rd;
        assign interrupt[gi] = r_ie & r_alarm;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_bus_timer
// Brief    : Self-checking bench for multi_channel_bus_timer: a 32-bit and an
//            8-bit instance (both PRESCALE=4) against a behavioural model.
//            Overrun expectations follow TIMER_OVERRUN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_bus_timer;

    localparam int P = 4;

    logic        clock = 1'b0;
    logic        resetN;
    logic        busEnable, busEnable8, busWrite;
    logic [5:2]  busAddress;
    logic [31:0] busWriteData;
    logic [31:0] busReadData, busReadData8;
    logic        busWait, busWait8;
    logic [3:0]  interrupt, interrupt8;

    int checks     = 0;
    int errors     = 0;
    int edges_done = 0;

    multi_channel_bus_timer #(.PRESCALE(P), .CHANNEL_BITS(2), .COUNTER_WIDTH(32)) u_dut (
        .clock(clock), .resetN(resetN), .busEnable(busEnable), .busWrite(busWrite),
        .busAddress(busAddress), .busWriteData(busWriteData), .busReadData(busReadData),
        .busWait(busWait), .interrupt(interrupt)
    );

    multi_channel_bus_timer #(.PRESCALE(P), .CHANNEL_BITS(2), .COUNTER_WIDTH(8)) u_dut8 (
        .clock(clock), .resetN(resetN), .busEnable(busEnable8), .busWrite(busWrite),
        .busAddress(busAddress), .busWriteData(busWriteData), .busReadData(busReadData8),
        .busWait(busWait8), .interrupt(interrupt8)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model: index [instance][channel] ----------
    logic [31:0] m_div [2][4];
    logic [31:0] m_cnt [2][4];
    bit          m_alarm [2][4];
    bit          m_ie [2][4];
    bit          m_os [2][4];
    bit          m_run [2][4];
    bit          m_ovr [2][4];
    int unsigned m_cyc;
    logic        m_tick, m_wr, m_exp, m_aold;
    logic [31:0] m_mask;

    function automatic logic [31:0] mask_of(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [3:0] a);
        int c;
        logic ovr;
        c = int'(a[3:2]);
`ifdef TIMER_OVERRUN_EN
        ovr = m_ovr[k][c];
`else
        ovr = 1'b0;
`endif
        case (a[1:0])
            2'd0:    return {27'd0, ovr, m_run[k][c], m_os[k][c], m_ie[k][c], m_alarm[k][c]};
            2'd1:    return m_div[k][c];
            2'd2:    return m_cnt[k][c];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] m_irq(input int k);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = m_ie[k][c] & m_alarm[k][c];
        return r;
    endfunction

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_cyc = 0;
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 4; c++) begin
                    m_div[k][c] = mask_of(k);
                    m_cnt[k][c] = mask_of(k);
                    m_alarm[k][c] = 0; m_ie[k][c] = 0; m_os[k][c] = 0;
                    m_run[k][c] = 1;   m_ovr[k][c] = 0;
                end
            end
        end else begin
            m_tick = ((m_cyc % P) == P - 1);
            m_cyc++;
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 4; c++) begin
                    m_mask = mask_of(k);
                    m_wr   = ((k == 0) ? busEnable : busEnable8) && busWrite && (busAddress[5:4] == 2'(c));
                    m_exp  = 1'b0;
                    m_aold = m_alarm[k][c];
                    if (m_wr && busAddress[3:2] == 2'd1) begin
                        m_div[k][c] = busWriteData & m_mask;
                        m_cnt[k][c] = busWriteData & m_mask;
                    end else if (m_tick && m_run[k][c]) begin
                        if (m_cnt[k][c] == 32'd1) begin
                            m_exp = 1'b1;
                            m_cnt[k][c] = m_div[k][c];
                        end else begin
                            m_cnt[k][c] = (m_cnt[k][c] - 32'd1) & m_mask;
                        end
                    end
                    if (m_wr && busAddress[3:2] == 2'd0) begin
                        m_alarm[k][c] = busWriteData[0];
                        m_ie[k][c]    = busWriteData[1];
                        m_os[k][c]    = busWriteData[2];
                        m_run[k][c]   = busWriteData[3];
                        if (!busWriteData[4]) m_ovr[k][c] = 0;
                        else if (m_exp && m_aold) m_ovr[k][c] = 1;
                    end else if (m_exp) begin
                        if (m_aold) m_ovr[k][c] = 1;
                        m_alarm[k][c] = 1;
                        if (m_os[k][c]) m_run[k][c] = 0;
                    end
                end
            end
        end
    end

    // ---------------- checking helpers --------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("irq",  {28'd0, interrupt},  {28'd0, m_irq(0)});
        check("irq8", {28'd0, interrupt8}, {28'd0, m_irq(1)});
        check("rd",   busReadData,  m_read(0, busAddress));
        check("rd8",  busReadData8, m_read(1, busAddress));
        check("wait", {31'd0, busWait | busWait8}, 32'd0);
    endtask

    // One bus cycle: drive after negedge, let posedge act, check at next negedge
    task automatic step(input logic en, input logic en8, input logic we,
                        input logic [3:0] a, input logic [31:0] d);
        busEnable = en; busEnable8 = en8; busWrite = we;
        busAddress = a; busWriteData = d;
        @(posedge clock);
        @(negedge clock);
        edges_done++;
        busEnable = 1'b0; busEnable8 = 1'b0; busWrite = 1'b0;
        check_all();
    endtask

    task automatic run_to(input int n);
        while (edges_done < n) step(1'b0, 1'b0, 1'b0, busAddress, 32'd0);
    endtask

    task automatic rd_expect(input string tag, input logic [3:0] a, input logic [31:0] e);
        busAddress = a;
        #1;
        check(tag, busReadData, e);
    endtask

    task automatic rd8_expect(input string tag, input logic [3:0] a, input logic [31:0] e);
        busAddress = a;
        #1;
        check(tag, busReadData8, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed and random stimulus --------------------------
    initial begin
        resetN = 1'b0; busEnable = 1'b0; busEnable8 = 1'b0; busWrite = 1'b0;
        busAddress = 4'd0; busWriteData = 32'd0;
        repeat (3) @(negedge clock);
        resetN = 1'b1;
        edges_done = 0;

        // Reset state
        rd_expect("rst_ctrl0", 4'b0000, 32'h0000_0008);
        rd_expect("rst_div0",  4'b0001, 32'hFFFF_FFFF);
        rd_expect("rst_cnt0",  4'b0010, 32'hFFFF_FFFF);
        check("rst_irq",  {28'd0, interrupt}, 32'd0);
        check("rst_wait", {31'd0, busWait},   32'd0);

        // ch1 periodic, divisor 3 (ticks after edges 3,7,11,...)
        step(1, 0, 1, 4'b0101, 32'd3);
        step(1, 0, 1, 4'b0100, 32'hA);
        rd_expect("ch1_cnt3", 4'b0110, 32'd3);
        run_to(4);  check("ch1_cnt2", busReadData, 32'd2);
        run_to(8);  check("ch1_cnt1", busReadData, 32'd1);
        run_to(11); check("ch1_irq_pre", {31'd0, interrupt[1]}, 32'd0);
        run_to(12);
        check("ch1_cnt_reload", busReadData, 32'd3);
        check("ch1_irq_set", {31'd0, interrupt[1]}, 32'd1);
        rd_expect("ch1_ctrl_alarm", 4'b0100, 32'hB);
        step(1, 0, 1, 4'b0100, 32'hA);
        check("ch1_irq_clear", {31'd0, interrupt[1]}, 32'd0);
        run_to(23); check("ch1_irq_pre2", {31'd0, interrupt[1]}, 32'd0);
        run_to(24); check("ch1_irq_again", {31'd0, interrupt[1]}, 32'd1);

        // ch2 one-shot, divisor 2
        step(1, 0, 1, 4'b1001, 32'd2);
        step(1, 0, 1, 4'b1000, 32'hE);
        run_to(31); rd_expect("ch2_ctrl_pre", 4'b1000, 32'hE);
        run_to(32);
        check("ch2_ctrl_fired", busReadData, 32'h7);
        check("ch2_irq", {31'd0, interrupt[2]}, 32'd1);
        rd_expect("ch2_cnt", 4'b1010, 32'd2);
        run_to(72);
        check("ch2_cnt_held", busReadData, 32'd2);
        rd_expect("ch2_ctrl_held", 4'b1000, 32'h7);

        // ch3: divisor write and CTRL write each landing on an expiry tick
        step(1, 0, 1, 4'b1101, 32'd2);
        run_to(76); rd_expect("ch3_cnt1", 4'b1110, 32'd1);
        run_to(79);
        step(1, 0, 1, 4'b1101, 32'd5);
        rd_expect("ch3_div_wins_cnt", 4'b1110, 32'd5);
        rd_expect("ch3_div_wins_ctrl", 4'b1100, 32'h8);
        run_to(99); rd_expect("ch3_cnt_pre", 4'b1110, 32'd1);
        step(1, 0, 1, 4'b1100, 32'h8);
        check("ch3_ctrl_wins", busReadData, 32'h8);
        rd_expect("ch3_reload", 4'b1110, 32'd5);

        // 8-bit instance, divisor 0 -> 256-tick period
        step(0, 1, 1, 4'b0001, 32'd0);
        run_to(104); rd8_expect("w8_cnt_ff", 4'b0010, 32'hFF);
        run_to(1123); rd8_expect("w8_ctrl_pre", 4'b0000, 32'h8);
        run_to(1124); check("w8_ctrl_fired", busReadData8, 32'h9);

        // ch0 divisor 1, alarm left pending across two expiries
        step(1, 0, 1, 4'b0001, 32'd1);
        run_to(1128); rd_expect("ovr_first", 4'b0000, 32'h9);
`ifdef TIMER_OVERRUN_EN
        run_to(1132); check("ovr_set", busReadData, 32'h19);
`else
        run_to(1132); check("ovr_absent", busReadData, 32'h9);
`endif
        step(1, 0, 1, 4'b0000, 32'h8);
        check("ovr_clear", busReadData, 32'h8);
        step(1, 0, 1, 4'b0000, 32'h18);
        check("ovr_no_set_by_write", busReadData, 32'h8);

        // Randomised bus traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  a;
            logic [31:0] d;
            a = 4'($urandom);
            if (a[1:0] == 2'd1) d = 32'($urandom_range(0, 6));
            else                d = $urandom;
            step(1'($urandom), 1'($urandom), 1'($urandom), a, d);
        end

        // Asynchronous reset with interrupt pending, no clock edge needed
        step(1, 0, 1, 4'b0100, 32'hB);
        check("pre_rst_irq", {31'd0, interrupt[1]}, 32'd1);
        #1 resetN = 1'b0;
        #1;
        check("arst_irq",  {28'd0, interrupt},  32'd0);
        check("arst_irq8", {28'd0, interrupt8}, 32'd0);
        check("arst_ctrl1", busReadData, 32'h8);
        rd_expect("arst_cnt1", 4'b0110, 32'hFFFF_FFFF);
        check("arst_cnt8", busReadData8, 32'hFF);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        edges_done = 0;
        run_to(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
